// File: rtl/totd_trigger_nch.sv
// Multi-channel occupancy trigger: per-channel hit windows feed a multiplicity
// vote that fires a one-cycle TRIG, then holds off for a programmable number of samples.
module totd_trigger_nch #(
  parameter int NCH       = 3,
  parameter int ADC_WIDTH = 12,
  parameter int WIN       = 122,
  parameter int OCC_BITS  = 8,
  parameter int INT_BITS  = 19,
  parameter int HOLD_BITS = 8
) (
  input  logic                      CLK120,
  input  logic                      RESET,
  input  logic                      SAMPLE_EN,
  input  logic [NCH*ADC_WIDTH-1:0]  ADC,
  input  logic [NCH*ADC_WIDTH-1:0]  THRES,
  input  logic [NCH*INT_BITS-1:0]   INTEGRAL,
  input  logic [INT_BITS-1:0]       INT_THRES,
  input  logic [NCH-1:0]            TRIG_ENABLE,
  input  logic [$clog2(NCH+1)-1:0]  MULTIPLICITY,
  input  logic [OCC_BITS-1:0]       OCCUPANCY,
  input  logic [HOLD_BITS-1:0]      HOLDOFF,
  output logic                      TRIG,
  output logic [NCH-1:0]            CH_TRIG,
  output logic [NCH*OCC_BITS-1:0]   OCC,
  output logic [15:0]               TRIG_COUNT
);
  localparam int MW = $clog2(NCH + 1);

  generate
    if (NCH < 1 || NCH > 8 || WIN < 2 || WIN > 255 || WIN >= (1 << OCC_BITS)) begin : g_param_err
      $error("totd_trigger_nch: illegal NCH, WIN or OCC_BITS");
    end
  endgenerate

  typedef enum logic {ARMED = 1'b0, HOLD = 1'b1} state_t;
  state_t state_q, state_d;

  logic                           en0_q, en1_q, en2_q, en3_q;
  logic [NCH-1:0][ADC_WIDTH-1:0]  adc_q, thres_q;
  logic [NCH-1:0][INT_BITS-1:0]   integral_q;
  logic [INT_BITS-1:0]            int_thres_q;
  logic [NCH-1:0]                 trig_en_q;
  logic [MW-1:0]                  mult_q;
  logic [OCC_BITS-1:0]            occ_thres_q;
  logic [HOLD_BITS-1:0]           holdoff_q, hold_cnt_q, hold_cnt_d;
  logic                           trig_q, trig_d;
  logic [15:0]                    trig_count_q, trig_count_d;
  logic [NCH-1:0]                 ch_trig;
  logic [NCH-1:0][OCC_BITS-1:0]   occ;
  logic [MW-1:0]                  ch_cnt;
  logic                           fire_cond, fire;

  // Stage 0: every input registered once; en1..en3 qualify the later stages.
  always_ff @(posedge CLK120) begin
    if (RESET) begin
      en0_q       <= 1'b0;
      en1_q       <= 1'b0;
      en2_q       <= 1'b0;
      en3_q       <= 1'b0;
      adc_q       <= '0;
      thres_q     <= '0;
      integral_q  <= '0;
      int_thres_q <= '0;
      trig_en_q   <= '0;
      mult_q      <= '0;
      occ_thres_q <= '0;
      holdoff_q   <= '0;
    end else begin
      en0_q       <= SAMPLE_EN;
      en1_q       <= en0_q;
      en2_q       <= en1_q;
      en3_q       <= en2_q;
      adc_q       <= ADC;
      thres_q     <= THRES;
      integral_q  <= INTEGRAL;
      int_thres_q <= INT_THRES;
      trig_en_q   <= TRIG_ENABLE;
      mult_q      <= MULTIPLICITY;
      occ_thres_q <= OCCUPANCY;
      holdoff_q   <= HOLDOFF;
    end
  end

  generate
    for (genvar i = 0; i < NCH; i++) begin : g_ch
      totd_trigger_ch #(
        .ADC_WIDTH (ADC_WIDTH),
        .WIN       (WIN),
        .OCC_BITS  (OCC_BITS),
        .INT_BITS  (INT_BITS)
      ) u_ch (
        .clk_i       (CLK120),
        .rst_i       (RESET),
        .en0_i       (en0_q),
        .en1_i       (en1_q),
        .en2_i       (en2_q),
        .clr_i       (fire),
        .adc_i       (adc_q[i]),
        .thres_i     (thres_q[i]),
        .trig_en_i   (trig_en_q[i]),
        .integral_i  (integral_q[i]),
        .int_thres_i (int_thres_q),
        .occ_thres_i (occ_thres_q),
        .ch_trig_o   (ch_trig[i]),
        .occ_o       (occ[i])
      );
    end
  endgenerate

  always_comb begin
    ch_cnt = '0;
    for (int i = 0; i < NCH; i++) ch_cnt = ch_cnt + MW'(ch_trig[i]);
  end

  assign fire_cond = (mult_q != '0) && (ch_cnt >= mult_q);

  always_ff @(posedge CLK120) begin
    if (RESET) begin
      state_q      <= ARMED;
      hold_cnt_q   <= '0;
      trig_q       <= 1'b0;
      trig_count_q <= '0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      trig_q       <= trig_d;
      trig_count_q <= trig_count_d;
    end
  end

  // HOLD always spends at least one cycle, so TRIG can never repeat back to back.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARMED:   if (fire_cond) state_d = HOLD;
      HOLD:    if (hold_cnt_q == '0) state_d = ARMED;
      default: state_d = ARMED;
    endcase
  end

  always_comb begin
    fire         = 1'b0;
    trig_d       = 1'b0;
    hold_cnt_d   = hold_cnt_q;
    trig_count_d = trig_count_q;
    case (state_q)
      ARMED: begin
        if (fire_cond) begin
          fire         = 1'b1;
          trig_d       = 1'b1;
          hold_cnt_d   = holdoff_q;
          trig_count_d = trig_count_q + 16'd1;
        end
      end
      HOLD: begin
        if (en3_q && hold_cnt_q != '0) hold_cnt_d = hold_cnt_q - 1'b1;
      end
      default: ;
    endcase
  end

  assign TRIG       = trig_q;
  assign CH_TRIG    = ch_trig;
  assign OCC        = occ;
  assign TRIG_COUNT = trig_count_q;
endmodule

// Per-channel hit detect, sliding occupancy window and channel trigger condition.
module totd_trigger_ch #(
  parameter int ADC_WIDTH = 12,
  parameter int WIN       = 122,
  parameter int OCC_BITS  = 8,
  parameter int INT_BITS  = 19
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en0_i,
  input  logic                 en1_i,
  input  logic                 en2_i,
  input  logic                 clr_i,
  input  logic [ADC_WIDTH-1:0] adc_i,
  input  logic [ADC_WIDTH-1:0] thres_i,
  input  logic                 trig_en_i,
  input  logic [INT_BITS-1:0]  integral_i,
  input  logic [INT_BITS-1:0]  int_thres_i,
  input  logic [OCC_BITS-1:0]  occ_thres_i,
  output logic                 ch_trig_o,
  output logic [OCC_BITS-1:0]  occ_o
);
  localparam logic [OCC_BITS-1:0] OCC_MAX = OCC_BITS'(WIN);

  logic                hit_q, hit_d;
  logic [WIN-1:0]      win_q, win_d;
  logic [OCC_BITS-1:0] occ_q, occ_d;
  logic                ch_trig_q, ch_trig_d;

  always_comb begin
    hit_d = hit_q;
    if (en0_i) hit_d = (adc_i > thres_i) && trig_en_i;
  end

  // occ tracks the window popcount; the bounds only guard against corruption.
  always_comb begin
    win_d = win_q;
    occ_d = occ_q;
    if (clr_i) begin
      win_d = '0;
      occ_d = '0;
    end else if (en1_i) begin
      win_d = {win_q[WIN-2:0], hit_q};
      if (hit_q && !win_q[WIN-1] && occ_q < OCC_MAX)
        occ_d = occ_q + 1'b1;
      else if (!hit_q && win_q[WIN-1] && occ_q != '0)
        occ_d = occ_q - 1'b1;
    end
  end

  always_comb begin
    ch_trig_d = ch_trig_q;
    if (clr_i)
      ch_trig_d = 1'b0;
    else if (en2_i)
      ch_trig_d = (occ_q > occ_thres_i) && (integral_i > int_thres_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_q     <= 1'b0;
      win_q     <= '0;
      occ_q     <= '0;
      ch_trig_q <= 1'b0;
    end else begin
      hit_q     <= hit_d;
      win_q     <= win_d;
      occ_q     <= occ_d;
      ch_trig_q <= ch_trig_d;
    end
  end

  assign ch_trig_o = ch_trig_q;
  assign occ_o     = occ_q;
endmodule
